// File: rtl/bitwise_unit.sv
// Bitwise ALU with optional result chaining, feeding a small FIFO output buffer.
// Outputs are driven from registered state only; results appear one edge after accept.
module bitwise_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic                       in_chain,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_zero,
    output logic                       out_ones,
    output logic [$clog2(DEPTH+1)-1:0] out_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] LP_LAST  = PW'(DEPTH-1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_chain;
    logic             r_run;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_head;

    // r_run holds in_ready low through reset and for the release cycle
    assign in_ready  = r_run && (r_count < LP_DEPTH);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_a       = in_chain ? r_chain : in_a;
    assign w_head    = r_mem[r_rptr];

    always_comb begin
        w_res = w_a;
        case (in_op)
            3'b000:  w_res = w_a & in_b;
            3'b001:  w_res = w_a | in_b;
            3'b010:  w_res = w_a ^ in_b;
            3'b011:  w_res = ~(w_a & in_b);
            3'b100:  w_res = ~(w_a | in_b);
            3'b101:  w_res = ~(w_a ^ in_b);
            3'b110:  w_res = w_a & ~in_b;
            default: w_res = w_a;
        endcase
    end

    assign out_result = out_valid ? w_head : '0;
    assign out_zero   = out_valid && (w_head == '0);
    assign out_ones   = out_valid && (&w_head);
    assign out_count  = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_chain <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_push) begin
                r_mem[r_wptr] <= w_res;
                r_chain       <= w_res;
                r_wptr        <= (r_wptr == LP_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LP_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_bitwise_unit.sv
// Drives a 32x2 and an 8x1 instance with shared stimulus and checks both against queue models.
module tb_bitwise_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic        in_chain = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_ready = 1'b0;

    logic        rdy32, ov32, z32, o32;
    logic [31:0] res32;
    logic [1:0]  cnt32;
    logic        rdy8, ov8, z8, o8;
    logic [7:0]  res8;
    logic [0:0]  cnt8;

    int total = 0;
    int bad   = 0;

    logic [31:0] q32[$];
    logic [7:0]  q8[$];
    logic [31:0] chain32 = '0;
    logic [7:0]  chain8 = '0;
    bit          mrdy = 0;

    always #5 clock = ~clock;

    bitwise_unit #(.WIDTH(32), .DEPTH(2)) dut32 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_op(in_op), .in_chain(in_chain), .in_a(in_a), .in_b(in_b),
        .out_valid(ov32), .out_ready(out_ready), .out_result(res32),
        .out_zero(z32), .out_ones(o32), .out_count(cnt32)
    );

    bitwise_unit #(.WIDTH(8), .DEPTH(1)) dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
        .in_op(in_op), .in_chain(in_chain), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
        .out_valid(ov8), .out_ready(out_ready), .out_result(res8),
        .out_zero(z8), .out_ones(o8), .out_count(cnt8)
    );

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] h32;
        logic [7:0]  h8;
        h32 = (q32.size() != 0) ? q32[0] : 32'd0;
        h8  = (q8.size() != 0) ? q8[0] : 8'd0;
        chk("valid32", ov32, q32.size() != 0);
        chk("result32", res32, h32);
        chk("zero32", z32, (q32.size() != 0) && (h32 == 0));
        chk("ones32", o32, (q32.size() != 0) && (h32 == 32'hFFFF_FFFF));
        chk("count32", cnt32, q32.size());
        chk("ready32", rdy32, mrdy && (q32.size() < 2));
        chk("valid8", ov8, q8.size() != 0);
        chk("result8", res8, h8);
        chk("zero8", z8, (q8.size() != 0) && (h8 == 0));
        chk("ones8", o8, (q8.size() != 0) && (h8 == 8'hFF));
        chk("count8", cnt8, q8.size());
        chk("ready8", rdy8, mrdy && (q8.size() < 1));
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid32", ov32, 0);
        chk("rst_result32", res32, 0);
        chk("rst_zero32", z32, 0);
        chk("rst_ones32", o32, 0);
        chk("rst_count32", cnt32, 0);
        chk("rst_ready32", rdy32, 0);
        chk("rst_valid8", ov8, 0);
        chk("rst_result8", res8, 0);
        chk("rst_count8", cnt8, 0);
        chk("rst_ready8", rdy8, 0);
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit push32, pop32, push8, pop8;
        logic [31:0] r32, r8;
        @(negedge clock);
        check_outputs();
        push32 = in_valid && mrdy && (q32.size() < 2);
        pop32  = out_ready && (q32.size() != 0);
        push8  = in_valid && mrdy && (q8.size() < 1);
        pop8   = out_ready && (q8.size() != 0);
        r32 = ref_op(in_op, in_chain ? chain32 : in_a, in_b);
        r8  = ref_op(in_op, in_chain ? {24'd0, chain8} : in_a, in_b);
        @(posedge clock);
        #1;
        if (pop32) void'(q32.pop_front());
        if (push32) begin q32.push_back(r32); chain32 = r32; end
        if (pop8) void'(q8.pop_front());
        if (push8) begin q8.push_back(r8[7:0]); chain8 = r8[7:0]; end
        if (reset) mrdy = 1;
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input bit ch, input logic [31:0] a, input logic [31:0] b, input bit rd);
        in_valid = v; in_op = op; in_chain = ch; in_a = a; in_b = b; out_ready = rd;
    endtask

    task automatic model_reset();
        q32.delete(); q8.delete();
        chain32 = '0; chain8 = '0; mrdy = 0;
    endtask

    logic [31:0] sweep_tbl [8];

    initial begin
        sweep_tbl[0] = 32'h00F0_1234; sweep_tbl[1] = 32'hFFF0_FFFF;
        sweep_tbl[2] = 32'hFF00_EDCB; sweep_tbl[3] = 32'hFF0F_EDCB;
        sweep_tbl[4] = 32'h000F_0000; sweep_tbl[5] = 32'h00FF_1234;
        sweep_tbl[6] = 32'hF000_0000; sweep_tbl[7] = 32'hF0F0_1234;

        // Power-on reset, released between edges
        #3;
        check_reset_outputs();
        @(posedge clock); #2; reset = 1'b1;
        drive(0, 3'd0, 0, 0, 0, 1);
        step();
        chk("ready_after_release", rdy32, 1);

        // Chained request first after reset uses A=0
        drive(1, 3'd7, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        step();
        chk("chain_first", res32, 0);
        chk("chain_first_zero", z32, 1);
        drive(0, 3'd0, 0, 0, 0, 1);
        step();

        // 8-bit, depth 1: NOR of zeros gives all ones
        drive(1, 3'd4, 0, 0, 0, 1);
        step();
        chk("w8_nor_ones_res", res8, 8'hFF);
        chk("w8_nor_ones_flag", o8, 1);
        chk("w8_full_ready", rdy8, 0);
        drive(0, 3'd0, 0, 0, 0, 1);
        step();

        // Op sweep with fixed operands
        for (int k = 0; k < 8; k++) begin
            drive(1, 3'(k), 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1);
            step();
            chk("sweep", res32, sweep_tbl[k]);
        end
        drive(0, 3'd0, 0, 0, 0, 1);
        step();

        // Chain: 1|2 = 3, then 3^3 = 0
        drive(1, 3'd1, 0, 32'h1, 32'h2, 1);
        step();
        chk("chain_or", res32, 32'h3);
        drive(1, 3'd2, 1, 32'hFFFF_FFFF, 32'h3, 1);
        step();
        chk("chain_xor", res32, 32'h0);
        chk("chain_xor_zero", z32, 1);
        drive(0, 3'd0, 0, 0, 0, 1);
        step();

        // Backpressure: three pushes with no pop, then drain
        for (int k = 0; k < 3; k++) begin
            drive(1, 3'd7, 0, 32'hA000_0000 + k, 0, 0);
            step();
        end
        chk("bp_full_count", cnt32, 2);
        chk("bp_full_ready", rdy32, 0);
        chk("bp_head", res32, 32'hA000_0000);
        drive(1, 3'd7, 0, 32'hB000_0000, 0, 1);
        step();
        chk("bp_no_accept_on_full_pop", cnt32, 1);
        chk("bp_drain_order", res32, 32'hA000_0001);
        drive(0, 3'd0, 0, 0, 0, 1);
        step();
        step();

        // Steady push+pop at count 1 across pointer wrap
        drive(1, 3'd7, 0, 32'h100, 0, 0);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1, 3'd7, 0, 32'h200 + k, 0, 1);
            step();
            chk("pp_count", cnt32, 1);
            chk("pp_order", res32, 32'h200 + k);
        end

        // Mid-stream async reset with two buffered results
        drive(1, 3'd7, 0, 32'h5555_0001, 0, 0);
        step();
        chk("pre_reset_count", cnt32, 2);
        #2; reset = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        drive(0, 3'd0, 0, 0, 0, 1);
        @(posedge clock); #2; reset = 1'b1;
        step();
        chk("post_reset_ready", rdy32, 1);
        chk("post_reset_empty", ov32, 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                  $urandom, $urandom, $urandom_range(0, 2) != 0);
            step();
        end
        drive(0, 3'd0, 0, 0, 0, 1);
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
